// File: rtl/axis_fifo_buffer_pkg.sv
// Shared helpers for the axis_fifo_buffer elastic buffer.
package axis_fifo_buffer_pkg;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI Stream bundle: manager drives tvalid/tdata, subordinate drives tready.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_fifo_buffer.sv
// DEPTH-entry AXI Stream elastic buffer with occupancy count, almost-full flag
// and synchronous flush; all handshake outputs come straight from registers.
module axis_fifo_buffer
    import axis_fifo_buffer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    axis_if.m             axis_mif,
    axis_if.s             axis_sif,
    input  logic          invalidate,
    output logic [CW-1:0] count,
    output logic          almost_full
);
    localparam int TDATA_WIDTH = $bits(axis_mif.tdata);
    localparam int AW          = $clog2(DEPTH);

    localparam logic [AW:0]   PTR_STEP  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_STEP  = CW'(1);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    if (TDATA_WIDTH <= 0) begin : g_bad_width
        $fatal(1, "axis_fifo_buffer: TDATA_WIDTH must be > 0");
    end
    if ($bits(axis_sif.tdata) != TDATA_WIDTH) begin : g_width_mismatch
        $fatal(1, "axis_fifo_buffer: TDATA_WIDTH differs between axis_mif and axis_sif");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $fatal(1, "axis_fifo_buffer: DEPTH must be a power of two and >= 2");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $fatal(1, "axis_fifo_buffer: AFULL_LEVEL must be in 1..DEPTH");
    end

    logic [TDATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [CW-1:0]          count_next;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;

    // The extra MSB on each pointer separates "same slot, same lap" (empty)
    // from "same slot, writer one lap ahead" (full).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign axis_sif.tready = !full;
    assign axis_mif.tvalid = !empty;
    assign axis_mif.tdata  = mem[rd_ptr[AW-1:0]];

    assign push = axis_sif.tvalid && !full;
    assign pop  = axis_mif.tready && !empty;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_STEP;
            2'b01:   count_next = count - CNT_STEP;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            // NOTE: storage is reset as well so tdata is deterministic out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (invalidate) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= axis_sif.tdata;
                wr_ptr              <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
            count       <= count_next;
            almost_full <= (count_next >= AFULL_CNT);
        end
    end

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// Self-checking bench for axis_fifo_buffer against a queue-based reference model.
module tb_axis_fifo_buffer;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          invalidate;
    logic [CW-1:0] count;
    logic          almost_full;

    axis_if #(.TDATA_WIDTH(8)) m_if ();
    axis_if #(.TDATA_WIDTH(8)) s_if ();

    axis_fifo_buffer #(
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axis_mif    (m_if),
        .axis_sif    (s_if),
        .invalidate  (invalidate),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q [$];
    logic       m_pop;
    logic [7:0] m_pop_data;
    logic       d_pop;
    logic [7:0] d_pop_data;
    logic       d_push;

    // Drive one cycle of inputs, observe the DUT handshake, advance the model.
    task automatic tick(input logic sv, input logic [7:0] sd, input logic mr, input logic inv);
        s_if.tvalid = sv;
        s_if.tdata  = sd;
        m_if.tready = mr;
        invalidate  = inv;
        #1;
        d_pop      = m_if.tvalid && m_if.tready && !inv;
        d_pop_data = m_if.tdata;
        d_push     = s_if.tvalid && s_if.tready && !inv;
        m_pop      = 1'b0;
        m_pop_data = 8'h00;
        if (inv) begin
            model_q.delete();
        end else begin
            logic pushed;
            pushed = sv && (model_q.size() < DEPTH);
            if (mr && model_q.size() > 0) begin
                m_pop      = 1'b1;
                m_pop_data = model_q.pop_front();
            end
            if (pushed) model_q.push_back(sd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        m_if.tready = 1'b0;
        invalidate  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        total++;
        if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
        total++;
        if (s_if.tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", s_if.tready); end
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++;
        if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        total++;
        if (m_if.tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata: got %h want 00", m_if.tdata); end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) tick(1'b1, 8'(k), 1'b1, 1'b0);
            else         tick(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (k == 1) begin
                if (d_pop !== 1'b0) begin bad++; $display("FAIL stream_latency: got pop=%b want 0", d_pop); end
            end else if (d_pop !== 1'b1 || d_pop_data !== 8'(k - 1)) begin
                bad++;
                $display("FAIL stream_beat[%0d]: got pop=%b data=%h want pop=1 data=%h", k, d_pop, d_pop_data, 8'(k - 1));
            end
            total++;
            if (count !== ((k <= 16) ? 3'd1 : 3'd0)) begin
                bad++;
                $display("FAIL stream_count[%0d]: got %0d want %0d", k, count, (k <= 16) ? 1 : 0);
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] want [5];
        want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            total++;
            if (count !== 3'(i + 1) || almost_full !== ((i + 1) >= AFL)) begin
                bad++;
                $display("FAIL fill[%0d]: got count=%0d af=%b want count=%0d af=%b", i, count, almost_full, i + 1, (i + 1) >= AFL);
            end
        end
        total++;
        if (s_if.tready !== 1'b0) begin bad++; $display("FAIL full_tready: got %b want 0", s_if.tready); end
        tick(1'b1, 8'hA4, 1'b0, 1'b0);
        total++;
        if (d_push !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_hold: got push=%b count=%0d want push=0 count=4", d_push, count);
        end
        // Pop while full with upstream valid: no push this cycle.
        tick(1'b1, 8'hA4, 1'b1, 1'b0);
        total++;
        if (d_pop !== 1'b1 || d_pop_data !== want[0] || d_push !== 1'b0 || count !== 3'd3 || s_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: got pop=%b data=%h push=%b count=%0d tready=%b want pop=1 data=a0 push=0 count=3 tready=1",
                     d_pop, d_pop_data, d_push, count, s_if.tready);
        end
        tick(1'b1, 8'hA4, 1'b0, 1'b0);
        total++;
        if (d_push !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_refill: got push=%b count=%0d want push=1 count=4", d_push, count);
        end
        for (int i = 1; i < 5; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            total++;
            if (d_pop !== 1'b1 || d_pop_data !== want[i]) begin
                bad++;
                $display("FAIL full_drain[%0d]: got pop=%b data=%h want pop=1 data=%h", i, d_pop, d_pop_data, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'h33 + 8'(i), 1'b1, 1'b0);
            total++;
            if (count !== 3'd3 || d_pop !== 1'b1 || d_pop_data !== 8'h30 + 8'(i) || d_push !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d]: got count=%0d pop=%b data=%h push=%b want count=3 pop=1 data=%h push=1",
                         i, count, d_pop, d_pop_data, d_push, 8'h30 + 8'(i));
            end
        end
        repeat (3) tick(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL b2b_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0, 1'b1);
        total++;
        if (count !== 3'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL flush_state: got count=%0d tvalid=%b tready=%b af=%b want 0 0 1 0",
                     count, m_if.tvalid, s_if.tready, almost_full);
        end
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        total++;
        if (d_pop !== 1'b1 || d_pop_data !== 8'h55) begin
            bad++;
            $display("FAIL flush_next: got pop=%b data=%h want pop=1 data=55", d_pop, d_pop_data);
        end
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL flush_drain: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1 || count !== 3'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got tvalid=%b tready=%b count=%0d af=%b want 0 1 0 0",
                     m_if.tvalid, s_if.tready, count, almost_full);
        end
        #2;
        rst = 1'b0;
        model_q.delete();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic sv, mr, inv;
            sv  = ($urandom_range(0, 3) != 0);
            mr  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 31) == 0);
            tick(sv, 8'($urandom), mr, inv);
            total++;
            if (d_pop !== m_pop || (m_pop && d_pop_data !== m_pop_data)) begin
                bad++;
                $display("FAIL rand_pop[%0d]: got pop=%b data=%h want pop=%b data=%h", i, d_pop, d_pop_data, m_pop, m_pop_data);
            end
            total++;
            if (count !== 3'(model_q.size()) || m_if.tvalid !== (model_q.size() > 0) ||
                s_if.tready !== (model_q.size() < DEPTH) || almost_full !== (model_q.size() >= AFL)) begin
                bad++;
                $display("FAIL rand_state[%0d]: got count=%0d tvalid=%b tready=%b af=%b want count=%0d",
                         i, count, m_if.tvalid, s_if.tready, almost_full, model_q.size());
            end
            if (model_q.size() > 0) begin
                total++;
                if (m_if.tdata !== model_q[0]) begin
                    bad++;
                    $display("FAIL rand_head[%0d]: got %h want %h", i, m_if.tdata, model_q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
